// File: rtl/strip_scan_sequencer_pkg.sv
// rtl/strip_scan_sequencer_pkg.sv - shared types, constants and expect-pattern helper for the strip scan sequencer
package strip_scan_sequencer_pkg;

  // Cycles allowed for each pulser_ready edge before the pulse is declared failed
  localparam int unsigned TIMEOUT = 255;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SETUP,
    S_SETTLE,
    S_FIRE,
    S_WAIT_BUSY,
    S_WAIT_READY,
    S_CHECK,
    S_NEXT,
    S_DONE
  } state_e;

  // Half-strip pair that a correctly injected strip lights up; shared with register readback
  function automatic logic [31:0] expect_pattern(input logic [3:0] strip);
    return 32'h3 << {strip, 1'b0};
  endfunction

endpackage

// File: rtl/sat_counter16.sv
// rtl/sat_counter16.sv - 16-bit clearable counter that sticks at all-ones
module sat_counter16 (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clr_i,
  input  logic        inc_i,
  output logic [15:0] count_o
);

  logic [15:0] count_q, count_d;

  // Clear has priority; increments stop at 16'hFFFF
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/strip_scan_sequencer.sv
// rtl/strip_scan_sequencer.sv - steps the mux across a strip range, fires the injector and scores readouts
module strip_scan_sequencer #(
  parameter int unsigned NPULSE_W = 8,
  parameter int unsigned SETTLE_W = 8,
  parameter int unsigned TIMEOUT  = strip_scan_sequencer_pkg::TIMEOUT
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                abort,
  input  logic [3:0]          first_strip,
  input  logic [3:0]          last_strip,
  input  logic [NPULSE_W-1:0] npulses,
  input  logic [SETTLE_W-1:0] settle_cycles,
  input  logic [31:0]         compare_mask,
  input  logic                pulser_ready,
  input  logic [31:0]         halfstrips_last,
  output logic                fire_pulse,
  output logic [3:0]          high_adr,
  output logic                mux_en,
  output logic [31:0]         halfstrips_expect,
  output logic                busy,
  output logic                done,
  output logic [15:0]         pass_cnt,
  output logic [15:0]         fail_cnt,
  output logic                timeout_flag,
  output logic [3:0]          first_fail_strip,
  output logic                first_fail_valid
);

  import strip_scan_sequencer_pkg::*;

  localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

  state_e              state_q, state_d;
  logic [3:0]          strip_q, strip_d;
  logic [3:0]          last_q, last_d;
  logic [NPULSE_W-1:0] npulses_q, npulses_d;
  logic [NPULSE_W-1:0] pulse_cnt_q, pulse_cnt_d;
  logic [SETTLE_W-1:0] settle_cfg_q, settle_cfg_d;
  logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                tmo_q, tmo_d;
  logic                fire_q, fire_d;
  logic [3:0]          high_adr_q, high_adr_d;
  logic                mux_en_q, mux_en_d;
  logic [31:0]         expect_q, expect_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                tmo_flag_q, tmo_flag_d;
  logic [3:0]          ff_strip_q, ff_strip_d;
  logic                ff_valid_q, ff_valid_d;
  logic                check_fail;
  logic                cnt_clr, pass_inc, fail_inc;

  // Next-state and next-output logic for the scan sequence
  always_comb begin
    state_d      = state_q;
    strip_d      = strip_q;
    last_d       = last_q;
    npulses_d    = npulses_q;
    pulse_cnt_d  = pulse_cnt_q;
    settle_cfg_d = settle_cfg_q;
    settle_cnt_d = settle_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    tmo_d        = tmo_q;
    fire_d       = 1'b0;
    high_adr_d   = high_adr_q;
    mux_en_d     = mux_en_q;
    expect_d     = expect_q;
    tmo_flag_d   = tmo_flag_q;
    ff_strip_d   = ff_strip_q;
    ff_valid_d   = ff_valid_q;
    cnt_clr      = 1'b0;
    pass_inc     = 1'b0;
    fail_inc     = 1'b0;
    // A timed-out pulse is a fail regardless of whatever readout is latched
    check_fail   = tmo_q || ((halfstrips_last & compare_mask) != (expect_q & compare_mask));

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          strip_d      = first_strip;
          last_d       = last_strip;
          npulses_d    = (npulses == '0) ? NPULSE_W'(1) : npulses;
          settle_cfg_d = settle_cycles;
          cnt_clr      = 1'b1;
          tmo_flag_d   = 1'b0;
          ff_strip_d   = '0;
          ff_valid_d   = 1'b0;
          state_d      = S_SETUP;
        end
      end
      S_SETUP: begin
        high_adr_d   = strip_q;
        expect_d     = expect_pattern(strip_q);
        mux_en_d     = 1'b1;
        settle_cnt_d = settle_cfg_q;
        pulse_cnt_d  = npulses_q;
        state_d      = S_SETTLE;
      end
      S_SETTLE: begin
        if (settle_cnt_q == '0) begin
          state_d = S_FIRE;
        end else begin
          settle_cnt_d = settle_cnt_q - SETTLE_W'(1);
        end
      end
      S_FIRE: begin
        if (pulser_ready) begin
          fire_d     = 1'b1;
          wait_cnt_d = '0;
          tmo_d      = 1'b0;
          state_d    = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY: begin
        if (!pulser_ready) begin
          wait_cnt_d = '0;
          state_d    = S_WAIT_READY;
        end else if (wait_cnt_q == WAIT_MAX) begin
          tmo_d      = 1'b1;
          tmo_flag_d = 1'b1;
          state_d    = S_CHECK;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      S_WAIT_READY: begin
        if (pulser_ready) begin
          state_d = S_CHECK;
        end else if (wait_cnt_q == WAIT_MAX) begin
          tmo_d      = 1'b1;
          tmo_flag_d = 1'b1;
          state_d    = S_CHECK;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      S_CHECK: begin
        pass_inc = !check_fail;
        fail_inc = check_fail;
        if (check_fail && !ff_valid_q) begin
          ff_strip_d = high_adr_q;
          ff_valid_d = 1'b1;
        end
        pulse_cnt_d = pulse_cnt_q - NPULSE_W'(1);
        state_d     = (pulse_cnt_q == NPULSE_W'(1)) ? S_NEXT : S_FIRE;
      end
      S_NEXT: begin
        if (strip_q == last_q) begin
          mux_en_d = 1'b0;
          state_d  = S_DONE;
        end else begin
          strip_d = strip_q + 4'd1;
          state_d = S_SETUP;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides everything, including a simultaneous start; results are left intact
    if (abort) begin
      state_d    = S_IDLE;
      mux_en_d   = 1'b0;
      fire_d     = 1'b0;
      cnt_clr    = 1'b0;
      pass_inc   = 1'b0;
      fail_inc   = 1'b0;
      tmo_flag_d = tmo_flag_q;
      ff_strip_d = ff_strip_q;
      ff_valid_d = ff_valid_q;
    end

    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      strip_q      <= '0;
      last_q       <= '0;
      npulses_q    <= '0;
      pulse_cnt_q  <= '0;
      settle_cfg_q <= '0;
      settle_cnt_q <= '0;
      wait_cnt_q   <= '0;
      tmo_q        <= 1'b0;
      fire_q       <= 1'b0;
      high_adr_q   <= '0;
      mux_en_q     <= 1'b0;
      expect_q     <= 32'h3;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      tmo_flag_q   <= 1'b0;
      ff_strip_q   <= '0;
      ff_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      strip_q      <= strip_d;
      last_q       <= last_d;
      npulses_q    <= npulses_d;
      pulse_cnt_q  <= pulse_cnt_d;
      settle_cfg_q <= settle_cfg_d;
      settle_cnt_q <= settle_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      tmo_q        <= tmo_d;
      fire_q       <= fire_d;
      high_adr_q   <= high_adr_d;
      mux_en_q     <= mux_en_d;
      expect_q     <= expect_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      tmo_flag_q   <= tmo_flag_d;
      ff_strip_q   <= ff_strip_d;
      ff_valid_q   <= ff_valid_d;
    end
  end

  sat_counter16 u_pass_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (cnt_clr),
    .inc_i   (pass_inc),
    .count_o (pass_cnt)
  );

  sat_counter16 u_fail_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (cnt_clr),
    .inc_i   (fail_inc),
    .count_o (fail_cnt)
  );

  assign fire_pulse        = fire_q;
  assign high_adr          = high_adr_q;
  assign mux_en            = mux_en_q;
  assign halfstrips_expect = expect_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign timeout_flag      = tmo_flag_q;
  assign first_fail_strip  = ff_strip_q;
  assign first_fail_valid  = ff_valid_q;

endmodule

// File: tb/tb_strip_scan_sequencer.sv
// tb/tb_strip_scan_sequencer.sv - self-checking bench for the strip scan sequencer
module tb_strip_scan_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        abort;
  logic [3:0]  first_strip;
  logic [3:0]  last_strip;
  logic [7:0]  npulses;
  logic [7:0]  settle_cycles;
  logic [31:0] compare_mask;
  logic        pulser_ready;
  logic [31:0] halfstrips_last;
  logic        fire_pulse;
  logic [3:0]  high_adr;
  logic        mux_en;
  logic [31:0] halfstrips_expect;
  logic        busy;
  logic        done;
  logic [15:0] pass_cnt;
  logic [15:0] fail_cnt;
  logic        timeout_flag;
  logic [3:0]  first_fail_strip;
  logic        first_fail_valid;

  int n_checks = 0;
  int n_fail   = 0;

  // Injector behaviour controls
  logic [31:0] corrupt_flip [16];
  bit          stuck_high  = 1'b0;
  int          fire_seen   = 0;
  int          hold_low_at = 0;

  int fire_addr [$];
  int exp_addr  [$];

  typedef struct {
    int f; int l; int np; int st; int cstrip;
    int exp_strobes; int exp_pass; int exp_fail; int exp_ffv; int exp_ffs;
  } vec_t;

  vec_t tbl [6];

  strip_scan_sequencer #(
    .NPULSE_W (8),
    .SETTLE_W (8),
    .TIMEOUT  (255)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .start             (start),
    .abort             (abort),
    .first_strip       (first_strip),
    .last_strip        (last_strip),
    .npulses           (npulses),
    .settle_cycles     (settle_cycles),
    .compare_mask      (compare_mask),
    .pulser_ready      (pulser_ready),
    .halfstrips_last   (halfstrips_last),
    .fire_pulse        (fire_pulse),
    .high_adr          (high_adr),
    .mux_en            (mux_en),
    .halfstrips_expect (halfstrips_expect),
    .busy              (busy),
    .done              (done),
    .pass_cnt          (pass_cnt),
    .fail_cnt          (fail_cnt),
    .timeout_flag      (timeout_flag),
    .first_fail_strip  (first_fail_strip),
    .first_fail_valid  (first_fail_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: strips visited in scan order and the resulting statistics
  task automatic model_scan(input int f, input int l, input int np, input logic [31:0] mask,
                            output int pass, output int fail, output int ffv, output int ffs);
    int s;
    int npe;
    s = f;
    npe = (np == 0) ? 1 : np;
    exp_addr.delete();
    pass = 0; fail = 0; ffv = 0; ffs = 0;
    while (1) begin
      exp_addr.push_back(s);
      if ((corrupt_flip[s] & mask) != 32'h0) begin
        fail += npe;
        if (ffv == 0) begin ffv = 1; ffs = s; end
      end else begin
        pass += npe;
      end
      if (s == l) break;
      s = (s + 1) % 16;
    end
  endtask

  task automatic start_scan(input int f, input int l, input int np, input int st, input logic [31:0] mask);
    @(negedge clk);
    first_strip   = 4'(f);
    last_strip    = 4'(l);
    npulses       = 8'(np);
    settle_cycles = 8'(st);
    compare_mask  = mask;
    fire_addr.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("done_reached", 32'(done), 32'd1);
  endtask

  // Compare recorded strobe addresses against the reference strip order
  task automatic check_sequence(input int np);
    int npe;
    npe = (np == 0) ? 1 : np;
    check("strobe_count", 32'(fire_addr.size()), 32'(exp_addr.size() * npe));
    for (int i = 0; i < fire_addr.size() && (i / npe) < exp_addr.size(); i++)
      check("strobe_addr", 32'(fire_addr[i]), 32'(exp_addr[i / npe]));
  endtask

  task automatic check_end(input int l, input int pass, input int fail, input int ffv, input int ffs);
    check("pass_cnt", 32'(pass_cnt), 32'(pass));
    check("fail_cnt", 32'(fail_cnt), 32'(fail));
    check("ff_valid", 32'(first_fail_valid), 32'(ffv));
    if (ffv != 0) check("ff_strip", 32'(first_fail_strip), 32'(ffs));
    check("busy_end", 32'(busy), 32'd0);
    check("mux_en_end", 32'(mux_en), 32'd0);
    check("high_adr_end", 32'(high_adr), 32'(l));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_fire"}, 32'(fire_pulse), 32'd0);
    check({tag, "_adr"}, 32'(high_adr), 32'd0);
    check({tag, "_mux"}, 32'(mux_en), 32'd0);
    check({tag, "_expect"}, halfstrips_expect, 32'h3);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_pass"}, 32'(pass_cnt), 32'd0);
    check({tag, "_fail"}, 32'(fail_cnt), 32'd0);
    check({tag, "_tmo"}, 32'(timeout_flag), 32'd0);
    check({tag, "_ffs"}, 32'(first_fail_strip), 32'd0);
    check({tag, "_ffv"}, 32'(first_fail_valid), 32'd0);
  endtask

  // Injector: answers each fire by dropping ready, presenting a readout, then recovering
  initial begin
    int adr;
    pulser_ready    = 1'b1;
    halfstrips_last = 32'h0;
    forever begin
      @(negedge clk);
      if (fire_pulse && !stuck_high) begin
        fire_seen++;
        adr = int'(high_adr);
        repeat ($urandom_range(1, 2)) @(negedge clk);
        pulser_ready    = 1'b0;
        halfstrips_last = (32'h3 << (2 * adr)) ^ corrupt_flip[adr];
        if (fire_seen == hold_low_at) begin
          while (hold_low_at != 0) @(negedge clk);
        end
        repeat ($urandom_range(1, 3)) @(negedge clk);
        pulser_ready = 1'b1;
      end
    end
  end

  // Strobe monitor: records addresses and checks strobe rules
  initial begin
    bit prev_fire;
    prev_fire = 1'b0;
    forever begin
      @(negedge clk);
      if (fire_pulse && reset_n) begin
        check("fire_needs_ready", 32'(pulser_ready), 32'd1);
        check("fire_not_back_to_back", 32'(prev_fire), 32'd0);
        check("expect_at_fire", halfstrips_expect, 32'h3 << (2 * int'(high_adr)));
        fire_addr.push_back(int'(high_adr));
      end
      prev_fire = fire_pulse;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p, fl, ffv, ffs, n, f, l, np, st, base;
    logic [31:0] mask;

    reset_n = 1'b0; start = 1'b0; abort = 1'b0;
    first_strip = '0; last_strip = '0; npulses = '0; settle_cycles = '0; compare_mask = '1;
    for (int i = 0; i < 16; i++) corrupt_flip[i] = 32'h0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // start -> busy next cycle, mux_en and address one cycle later
    start_scan(9, 9, 1, 3, 32'hFFFF_FFFF);
    check("busy_after_start", 32'(busy), 32'd1);
    check("mux_en_1cyc", 32'(mux_en), 32'd0);
    @(negedge clk);
    check("mux_en_2cyc", 32'(mux_en), 32'd1);
    check("adr_2cyc", 32'(high_adr), 32'd9);
    check("expect_2cyc", halfstrips_expect, 32'h3 << 18);
    wait_done();
    check_end(9, 1, 0, 0, 0);

    // Directed table
    tbl[0] = '{3, 3, 2, 4, -1, 2, 2, 0, 0, 0};
    tbl[1] = '{0, 15, 1, 0, 5, 16, 15, 1, 1, 5};
    tbl[2] = '{14, 1, 1, 1, -1, 4, 4, 0, 0, 0};
    tbl[3] = '{2, 4, 0, 2, -1, 3, 3, 0, 0, 0};
    tbl[4] = '{7, 7, 3, 0, 7, 3, 0, 3, 1, 7};
    tbl[5] = '{15, 0, 2, 0, 0, 4, 2, 2, 1, 0};
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 16; i++) corrupt_flip[i] = 32'h0;
      if (tbl[t].cstrip >= 0) corrupt_flip[tbl[t].cstrip] = 32'h1 << (2 * tbl[t].cstrip);
      model_scan(tbl[t].f, tbl[t].l, tbl[t].np, 32'hFFFF_FFFF, p, fl, ffv, ffs);
      start_scan(tbl[t].f, tbl[t].l, tbl[t].np, tbl[t].st, 32'hFFFF_FFFF);
      wait_done();
      check("tbl_strobes", 32'(fire_addr.size()), 32'(tbl[t].exp_strobes));
      check_sequence(tbl[t].np);
      check_end(tbl[t].l, tbl[t].exp_pass, tbl[t].exp_fail, tbl[t].exp_ffv, tbl[t].exp_ffs);
      check("tbl_tmo", 32'(timeout_flag), 32'd0);
    end

    // Randomized scans against the reference model
    for (int r = 0; r < 6; r++) begin
      f = int'($urandom_range(0, 15));
      l = int'($urandom_range(0, 15));
      np = int'($urandom_range(0, 3));
      st = int'($urandom_range(0, 5));
      mask = $urandom;
      for (int i = 0; i < 16; i++)
        corrupt_flip[i] = ($urandom_range(0, 3) == 0) ? $urandom : 32'h0;
      model_scan(f, l, np, mask, p, fl, ffv, ffs);
      start_scan(f, l, np, st, mask);
      wait_done();
      check_sequence(np);
      check_end(l, p, fl, ffv, ffs);
      check("rand_tmo", 32'(timeout_flag), 32'd0);
    end
    for (int i = 0; i < 16; i++) corrupt_flip[i] = 32'h0;

    // Ready never drops after a fire -> timeout recorded as a fail, scan completes
    stuck_high = 1'b1;
    start_scan(6, 6, 1, 0, 32'hFFFF_FFFF);
    n = 0;
    while (!fire_pulse && n < 100) begin @(negedge clk); n++; end
    check("tmo_fire_seen", 32'(fire_pulse), 32'd1);
    n = 0;
    while (fail_cnt == 16'd0 && n < 400) begin @(negedge clk); n++; end
    check("tmo_latency", 32'(n >= 256 && n <= 258), 32'd1);
    wait_done();
    check("tmo_flag", 32'(timeout_flag), 32'd1);
    check_end(6, 0, 1, 1, 6);
    stuck_high = 1'b0;
    repeat (2) @(negedge clk);

    // Abort while waiting for ready to return
    base = fire_seen;
    hold_low_at = base + 3;
    start_scan(0, 15, 1, 0, 32'hFFFF_FFFF);
    n = 0;
    while (fire_seen < base + 3 && n < 2000) begin @(negedge clk); n++; end
    n = 0;
    while (pulser_ready && n < 20) begin @(negedge clk); n++; end
    check("abort_ready_low", 32'(pulser_ready), 32'd0);
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_mux", 32'(mux_en), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_pass_kept", 32'(pass_cnt), 32'd2);
    check("abort_fail_kept", 32'(fail_cnt), 32'd0);
    hold_low_at = 0;
    repeat (6) @(negedge clk);
    start_scan(3, 3, 1, 0, 32'hFFFF_FFFF);
    check("restart_clears_pass", 32'(pass_cnt), 32'd0);
    wait_done();
    check_end(3, 1, 0, 0, 0);

    // Reset in the middle of a scan
    base = fire_seen;
    start_scan(0, 15, 1, 0, 32'hFFFF_FFFF);
    n = 0;
    while (fire_seen < base + 2 && n < 2000) begin @(negedge clk); n++; end
    reset_n = 1'b0;
    @(negedge clk);
    check_all_zero("midreset");
    reset_n = 1'b1;
    repeat (8) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
